// File: rtl/dma_controller.sv
// Single-channel word-copy DMA engine: CPU-programmed SRC/DST/LEN, one read
// cycle followed by one write cycle per word, with start/abort via CTRL.
`timescale 1ns/1ps
module dma_controller #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [31:0]      cfg_wdata,
  output logic             rd_en,
  output logic [31:0]      rd_addr,
  input  logic [31:0]      rd_data,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             hal,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_B = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]        hold_q, hold_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic               hal_q, hal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ctrl_wr, start, abort;

  // Abort wins over start when both bits are written together.
  assign ctrl_wr = cfg_we && (cfg_sel == 2'd3);
  assign start   = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign abort   = ctrl_wr && cfg_wdata[1];

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    hold_d   = hold_q;
    rem_d    = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          unique case (cfg_sel)
            2'd0:    src_d = cfg_wdata;
            2'd1:    dst_d = cfg_wdata;
            2'd2:    len_d = LEN_W'(cfg_wdata);
            default: ;
          endcase
        end
        if (start) begin
          rd_ptr_d = src_q;
          wr_ptr_d = dst_q;
          rem_d    = len_q;
          state_d  = (len_q != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        hold_d   = rd_data;
        rd_ptr_d = rd_ptr_q + ADDR_W'(WORD_B);
        state_d  = abort ? S_IDLE : S_WRITE;
      end
      S_WRITE: begin
        // The write in flight still completes its bookkeeping on abort.
        wr_ptr_d = wr_ptr_q + ADDR_W'(WORD_B);
        rem_d    = rem_q - LEN_W'(1);
        if (abort)                   state_d = S_IDLE;
        else if (rem_q == LEN_W'(1)) state_d = S_DONE;
        else                         state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rd_en_d = (state_d == S_READ);
    wr_en_d = (state_d == S_WRITE);
    hal_d   = (state_d == S_READ) || (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      hold_q   <= '0;
      rem_q    <= '0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      hal_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      hold_q   <= hold_d;
      rem_q    <= rem_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      hal_q    <= hal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_ptr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_ptr_q;
  assign wr_data   = hold_q;
  assign hal       = hal_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed self-checking bench for dma_controller: copy, zero length, wrap,
// abort, mid-transfer reset and ignored writes while busy.
`timescale 1ns/1ps
module tb_dma_controller;

  localparam int unsigned LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [31:0]      cfg_wdata;
  logic             rd_en;
  logic [31:0]      rd_addr;
  logic [31:0]      rd_data;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             hal;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] remaining;

  dma_controller #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hal       (hal),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;

  logic [31:0] mem [4];
  assign rd_data = rd_en ? mem[rd_addr[3:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hal_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int overlap = 0;
  int stray_en = 0;
  logic [31:0] ra_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (hal) hal_cnt <= hal_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rd_en) ra_q.push_back(rd_addr);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (rd_en && wr_en) overlap <= overlap + 1;
    if ((rd_en || wr_en) && !hal) stray_en <= stray_en + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called one step after a rising edge; returns one step after the next.
  task automatic cfg(input logic [1:0] sel, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    cfg_sel   = 2'd0;
    cfg_wdata = 32'h0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  int s, h0, r0, w0, d0;

  initial begin
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hal", 32'(hal), 32'd0);
    check("rst_en", 32'({rd_en, wr_en, done}), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 32'd0);

    // Basic copy of three words.
    cfg(2'd0, 32'h100); cfg(2'd1, 32'h200); cfg(2'd2, 32'd3);
    h0 = hal_cnt; r0 = ra_q.size(); w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    s = cyc;
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_rem_load", 32'(remaining), 32'd3);
    wait_done("basic");
    check("basic_latency", 32'(done_cyc - s + 1), 32'd7);
    check("basic_hal_cycles", 32'(hal_cnt - h0), 32'd6);
    check("basic_reads", 32'(ra_q.size() - r0), 32'd3);
    check("basic_writes", 32'(wa_q.size() - w0), 32'd3);
    check("basic_wa0", wa_q[w0], 32'h200);
    check("basic_wd0", wd_q[w0], WA);
    check("basic_wa1", wa_q[w0+1], 32'h204);
    check("basic_wd1", wd_q[w0+1], WB);
    check("basic_wa2", wa_q[w0+2], 32'h208);
    check("basic_wd2", wd_q[w0+2], WC);
    check("basic_rem_end", 32'(remaining), 32'd0);

    // Zero length.
    cfg(2'd2, 32'd0);
    h0 = hal_cnt; r0 = ra_q.size(); w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    s = cyc;
    wait_done("zero");
    check("zero_latency", 32'(done_cyc - s + 1), 32'd1);
    check("zero_hal", 32'(hal_cnt - h0), 32'd0);
    check("zero_rw", 32'((ra_q.size() - r0) + (wa_q.size() - w0)), 32'd0);

    // Source address wrap.
    cfg(2'd0, 32'hFFFF_FFFC); cfg(2'd1, 32'h400); cfg(2'd2, 32'd2);
    r0 = ra_q.size(); w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    wait_done("wrap");
    check("wrap_ra0", ra_q[r0], 32'hFFFF_FFFC);
    check("wrap_ra1", ra_q[r0+1], 32'h0);
    check("wrap_wd0", wd_q[w0], WD);
    check("wrap_wd1", wd_q[w0+1], WA);
    check("wrap_wa1", wa_q[w0+1], 32'h404);

    // Abort during the second WRITE of a four-word copy.
    cfg(2'd0, 32'h100); cfg(2'd1, 32'h200); cfg(2'd2, 32'd4);
    w0 = wa_q.size(); d0 = done_cnt;
    cfg(2'd3, 32'h1);
    repeat (3) begin @(posedge clk); #1; end
    check("abort_in_write", 32'(wr_en), 32'd1);
    cfg(2'd3, 32'h2);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hal", 32'(hal), 32'd0);
    check("abort_remaining", 32'(remaining), 32'd2);
    check("abort_writes", 32'(wa_q.size() - w0), 32'd2);
    repeat (5) begin @(posedge clk); #1; end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_still_idle", 32'(busy), 32'd0);

    // Asynchronous reset during the READ of word 2.
    cfg(2'd2, 32'd3);
    cfg(2'd3, 32'h1);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_rd_en", 32'(rd_en), 32'd1);
    check("mid_rd_addr", rd_addr, 32'h104);
    rst_n = 1'b0;
    #1;
    check("arst_strobes", 32'({rd_en, wr_en, hal, busy, done}), 32'd0);
    check("arst_rd_addr", rd_addr, 32'h0);
    check("arst_wr_addr", wr_addr, 32'h0);
    check("arst_wr_data", wr_data, 32'h0);
    check("arst_remaining", 32'(remaining), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("arst_release_idle", 32'(busy), 32'd0);
    cfg(2'd3, 32'h1);
    s = cyc;
    wait_done("arst_len0");
    check("arst_len_cleared", 32'(done_cyc - s + 1), 32'd1);
    cfg(2'd2, 32'd1);
    r0 = ra_q.size(); w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    wait_done("arst_one");
    check("arst_src_cleared", ra_q[r0], 32'h0);
    check("arst_dst_cleared", wa_q[w0], 32'h0);
    check("arst_one_data", wd_q[w0], WA);

    // Configuration writes and start while busy are ignored.
    cfg(2'd0, 32'h100); cfg(2'd1, 32'h300); cfg(2'd2, 32'd2);
    w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    s = cyc;
    cfg(2'd2, 32'd9);
    cfg(2'd3, 32'h1);
    wait_done("ign");
    check("ign_latency", 32'(done_cyc - s + 1), 32'd5);
    check("ign_writes", 32'(wa_q.size() - w0), 32'd2);
    check("ign_wa1", wa_q[w0+1], 32'h304);
    check("ign_wd1", wd_q[w0+1], WB);
    w0 = wa_q.size();
    cfg(2'd3, 32'h1);
    s = cyc;
    wait_done("rerun");
    check("rerun_latency", 32'(done_cyc - s + 1), 32'd5);
    check("rerun_writes", 32'(wa_q.size() - w0), 32'd2);
    check("rerun_wa0", wa_q[w0], 32'h300);

    check("never_rd_and_wr", 32'(overlap), 32'd0);
    check("strobe_without_hal", 32'(stray_en), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
